note_sequencer_ctrl: RTL and testbench
======================================

Name: note_sequencer_ctrl

Overview:
- Multi-voice successor to the single-note play controller in the music player.
- Steps a note address through song ROM and waits for every enabled voice to finish its note before advancing.
- Detects end of song, from a zero-duration note or the last address, and optionally loops.
- Sits between the play/loop user controls and the song ROM plus the per-voice note players.

Parameters:
- NUM_VOICES, 2, number of note-player voices whose note_done must be collected.
- ADDR_W, 5, song ROM address width; the song holds at most 2^ADDR_W notes.
- DUR_W, 6, width of the duration field read from ROM.
- ROM_LAT, 1, ROM read latency in cycles after note_addr changes; must be >= 1.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous, active-high reset.
- play, input, 1, level: 1 = play, 0 = stop/pause.
- loop_en, input, 1, level: restart from address 0 at end of song.
- voice_en, input, NUM_VOICES, per-voice enable; a disabled voice counts as done.
- note_done, input, NUM_VOICES, per-voice one-cycle done pulses.
- note_dur, input, DUR_W, duration of the note at note_addr, valid ROM_LAT cycles after an address change.
- note_addr, output, ADDR_W, current song ROM address.
- new_note, output, 1, one-cycle pulse: start playing the note at note_addr.
- song_done, output, 1, one-cycle pulse at end of song.
- busy, output, 1, high whenever state != IDLE.

Behaviour:
- Reset (clk edge with reset=1, dominates everything else):
  - state = IDLE, note_addr = 0, done_seen = 0, lat_cnt = 0.
  - new_note = 0, song_done = 0, busy = 0.
  - Reset mid-note aborts immediately; no song_done pulse is issued.
- Outputs are Moore decodes of state:
  - new_note = (state == NEW_NOTE).
  - song_done = (state == END).
  - busy = (state != IDLE).
- IDLE:
  - play = 1 -> FETCH. note_addr is held, so a paused song resumes by replaying the current note.
- FETCH:
  - lat_cnt counts ROM_LAT cycles; the state lasts exactly ROM_LAT cycles.
  - On the final cycle: note_dur == 0 -> END; otherwise -> NEW_NOTE.
  - play is ignored in FETCH.
- NEW_NOTE:
  - Lasts one cycle; done_seen is cleared to 0; -> WAIT.
  - note_done pulses arriving in this cycle are ignored.
- WAIT:
  - Each cycle: done_seen |= note_done.
  - all_done = &(done_seen | note_done | ~voice_en), so a same-cycle pulse counts.
  - Priority: play = 0 -> IDLE (address kept); else all_done -> NEXT_NOTE; else stay.
  - voice_en is sampled live. If voice_en is all zeros, WAIT exits to NEXT_NOTE on its first cycle.
- NEXT_NOTE (one cycle):
  - note_addr == 2^ADDR_W - 1 -> END, with note_addr unchanged.
  - Otherwise note_addr <= note_addr + 1 -> FETCH.
  - No wrap-around happens through increment.
- END (one cycle):
  - note_addr <= 0.
  - Next state: (loop_en & play) ? FETCH : IDLE.
- Latency figures:
  - play rising edge in IDLE to new_note = 1 + ROM_LAT cycles.
  - Last voice done to the next new_note = 2 + ROM_LAT cycles.
- Widths:
  - lat_cnt is sized to hold ROM_LAT; clog2 with a minimum width of 1.
  - done_seen is NUM_VOICES bits.
  - All address arithmetic is unsigned, ADDR_W bits.

Test Plan:
- Basic sequence, defaults, ROM durations {5,3,0}, all voices enabled, play = 1:
  - new_note at addr 0 and addr 1, then song_done with addr 2; then IDLE, note_addr = 0, busy = 0.
- Voice collection: in WAIT, pulse voice0 at cycle t and voice1 at t+4:
  - Stays in WAIT until t+4; new_note at t+4+2+ROM_LAT.
  - Pulse both in the same cycle -> advances at once.
- Disabled voice: voice_en = 2'b01, only voice0 pulses -> advances. voice_en = 0 -> WAIT lasts one cycle.
- Pause/resume: drop play in WAIT at addr 3 -> IDLE with note_addr = 3; raise play -> new_note re-issued at addr 3.
- Loop and full ROM: loop_en = 1, all 32 durations nonzero:
  - After addr 31 completes, song_done pulses and note_addr = 0, then new_note at addr 0.
  - With loop_en = 0 the block goes to IDLE instead.
- Reset mid-WAIT at addr 7, plus a ROM_LAT = 3 build:
  - Reset gives all outputs 0 and addr 0, with no song_done.
  - Next start shows new_note 4 cycles after play.

Source files
------------

// File: rtl/note_sequencer_ctrl.sv
// Multi-voice note sequencer: walks the song ROM, starts each note on every voice,
// and advances only once every enabled voice has reported its note finished.
module note_sequencer_ctrl #(
    parameter int NUM_VOICES = 2,
    parameter int ADDR_W     = 5,
    parameter int DUR_W      = 6,
    parameter int ROM_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  play,
    input  logic                  loop_en,
    input  logic [NUM_VOICES-1:0] voice_en,
    input  logic [NUM_VOICES-1:0] note_done,
    input  logic [DUR_W-1:0]      note_dur,
    output logic [ADDR_W-1:0]     note_addr,
    output logic                  new_note,
    output logic                  song_done,
    output logic                  busy
);

    localparam int LAT_W = ($clog2(ROM_LAT + 1) > 1) ? $clog2(ROM_LAT + 1) : 1;
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(ROM_LAT - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_NEW_NOTE  = 3'd2;
    localparam logic [2:0] S_WAIT      = 3'd3;
    localparam logic [2:0] S_NEXT_NOTE = 3'd4;
    localparam logic [2:0] S_END       = 3'd5;

    logic [2:0]            state;
    logic [2:0]            state_next;
    logic [LAT_W-1:0]      lat_cnt;
    logic [NUM_VOICES-1:0] done_seen;
    logic                  all_done;
    logic                  fetch_last;

    // A done pulse in the same cycle counts, and disabled voices are always done.
    assign all_done   = &(done_seen | note_done | ~voice_en);
    assign fetch_last = (lat_cnt == LAT_LAST);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:      if (play) state_next = S_FETCH;
            S_FETCH:     if (fetch_last) state_next = (note_dur == '0) ? S_END : S_NEW_NOTE;
            S_NEW_NOTE:  state_next = S_WAIT;
            S_WAIT: begin
                if (!play)
                    state_next = S_IDLE;
                else if (all_done)
                    state_next = S_NEXT_NOTE;
            end
            S_NEXT_NOTE: state_next = (note_addr == ADDR_LAST) ? S_END : S_FETCH;
            S_END:       state_next = (loop_en && play) ? S_FETCH : S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    // Pausing leaves note_addr alone so a resume replays the interrupted note.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            note_addr <= '0;
            done_seen <= '0;
            lat_cnt   <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_FETCH:     lat_cnt <= fetch_last ? '0 : lat_cnt + 1'b1;
                S_NEW_NOTE:  done_seen <= '0;
                S_WAIT:      done_seen <= done_seen | note_done;
                S_NEXT_NOTE: if (note_addr != ADDR_LAST) note_addr <= note_addr + 1'b1;
                S_END:       note_addr <= '0;
                default:     ;
            endcase
        end
    end

    assign new_note  = (state == S_NEW_NOTE);
    assign song_done = (state == S_END);
    assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_note_sequencer_ctrl.sv
// Bench for note_sequencer_ctrl: a note-level song model predicts every new_note and
// song_done (address and cycle); a second instance built with ROM_LAT = 3 checks start latency.
module tb_note_sequencer_ctrl;

    localparam int DW   = 6;
    localparam int AW   = 5;
    localparam int LAT  = 1;
    localparam int LAT3 = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          play = 1'b0;
    logic          loop_en = 1'b0;
    logic [1:0]    voice_en = 2'b11;
    logic [1:0]    note_done = 2'b00;
    logic [DW-1:0] note_dur, note_dur3;
    logic [AW-1:0] note_addr, note_addr3;
    logic          new_note, song_done, busy;
    logic          new_note3, song_done3, busy3;
    logic [AW-1:0] addr3_d1, addr3_d2;
    logic [DW-1:0] rom [32];

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        bit is_end;
        int addr;
        int at;
    } ev_t;
    ev_t exp_q[$];

    int cur_addr = 0;
    int next_t = 0;
    bit ended = 1'b0;

    note_sequencer_ctrl #(.NUM_VOICES(2), .ADDR_W(AW), .DUR_W(DW), .ROM_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .play(play), .loop_en(loop_en),
        .voice_en(voice_en), .note_done(note_done), .note_dur(note_dur),
        .note_addr(note_addr), .new_note(new_note), .song_done(song_done), .busy(busy)
    );

    note_sequencer_ctrl #(.NUM_VOICES(2), .ADDR_W(AW), .DUR_W(DW), .ROM_LAT(LAT3)) dut3 (
        .clk(clk), .reset(reset), .play(play), .loop_en(loop_en),
        .voice_en(voice_en), .note_done(note_done), .note_dur(note_dur3),
        .note_addr(note_addr3), .new_note(new_note3), .song_done(song_done3), .busy(busy3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ROM with ROM_LAT-1 address stages ahead of a combinational array read.
    assign note_dur = rom[note_addr];
    always @(posedge clk) begin
        addr3_d1 <= note_addr3;
        addr3_d2 <= addr3_d1;
    end
    assign note_dur3 = rom[addr3_d2];

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic wait_cycle(input int k);
        if (cyc > k) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL schedule: at cycle %0d, wanted %0d", cyc, k);
        end
        while (cyc < k) @(negedge clk);
    endtask

    task automatic expectEvent(input bit is_end, input int addr, input int at);
        ev_t e;
        e.is_end = is_end;
        e.addr   = addr;
        e.at     = at;
        exp_q.push_back(e);
    endtask

    task automatic startPlay();
        play   = 1'b1;
        ended  = 1'b0;
        next_t = cyc + 1 + LAT;
        expectEvent(1'b0, cur_addr, next_t);
    endtask

    task automatic finishSong(input int e_t);
        expectEvent(1'b1, cur_addr, e_t);
        cur_addr = 0;
        if (loop_en) begin
            next_t = e_t + 1 + LAT;
            expectEvent(1'b0, 0, next_t);
        end
        wait_cycle(e_t + 1);
        checkOutput("addr_after_end", int'(note_addr), 0);
        checkOutput("busy_after_end", int'(busy), loop_en ? 1 : 0);
        if (!loop_en) begin
            play  = 1'b0;
            ended = 1'b1;
        end
    endtask

    // Plays notes starting from the pending new_note at next_t; each enabled voice
    // finishes once at a random delay, disabled voices chatter randomly.
    task automatic applyStimulus(input int n_notes, input bit rand_en);
        for (int k = 0; k < n_notes && !ended; k++) begin
            int         dly [2];
            int         last;
            logic [1:0] en;
            logic [1:0] mask;
            en = 2'b11;
            if (rand_en && $urandom_range(0, 3) == 0) en = 2'($urandom_range(0, 2));
            wait_cycle(next_t);
            voice_en  = en;
            note_done = ($urandom_range(0, 2) == 0) ? 2'b11 : 2'b00;
            last = next_t + 1;
            for (int v = 0; v < 2; v++) begin
                dly[v] = next_t + 1 + int'($urandom_range(0, 5));
                if (en[v] && dly[v] > last) last = dly[v];
            end
            for (int c = next_t + 1; c <= last; c++) begin
                wait_cycle(c);
                mask = 2'b00;
                for (int v = 0; v < 2; v++)
                    mask[v] = en[v] ? (c == dly[v]) : 1'($urandom_range(0, 1));
                note_done = mask;
            end
            wait_cycle(last + 1);
            note_done = 2'b00;
            if (cur_addr == 31) begin
                finishSong(last + 2);
            end else begin
                cur_addr++;
                if (rom[cur_addr] == 0) begin
                    finishSong(last + 2 + LAT);
                end else begin
                    next_t = last + 2 + LAT;
                    expectEvent(1'b0, cur_addr, next_t);
                end
            end
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_new_note"}, int'(new_note), 0);
        checkOutput({tag, "_song_done"}, int'(song_done), 0);
        checkOutput({tag, "_addr"}, int'(note_addr), 0);
        checkOutput({tag, "_busy3"}, int'(busy3), 0);
        checkOutput({tag, "_new_note3"}, int'(new_note3), 0);
        checkOutput({tag, "_addr3"}, int'(note_addr3), 0);
    endtask

    always @(negedge clk) begin
        if (!reset && (new_note || song_done)) begin
            ev_t e;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL unexpected_event: new_note=%0d song_done=%0d addr=%0d cycle=%0d",
                         new_note, song_done, note_addr, cyc);
            end else begin
                e = exp_q.pop_front();
                checkOutput("event_kind", int'(song_done), int'(e.is_end));
                checkOutput("event_addr", int'(note_addr), e.addr);
                checkOutput("event_cycle", cyc, e.at);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int p;
        int r;
        int c0;
        for (int i = 0; i < 32; i++) rom[i] = DW'($urandom_range(1, 63));
        repeat (3) @(negedge clk);
        checkResetState("reset");
        reset = 1'b0;

        $display("[TB] basic three-note song");
        rom[0] = 6'd5;
        rom[1] = 6'd3;
        rom[2] = 6'd0;
        cur_addr = 0;
        @(negedge clk);
        startPlay();
        applyStimulus(8, 1'b0);

        $display("[TB] pause and resume at address 3");
        for (int i = 0; i < 32; i++) rom[i] = DW'($urandom_range(1, 63));
        wait_cycle(cyc + 2);
        startPlay();
        applyStimulus(3, 1'b1);
        wait_cycle(next_t);
        voice_en  = 2'b11;
        note_done = 2'b00;
        p = next_t + 1 + int'($urandom_range(0, 3));
        wait_cycle(p);
        play = 1'b0;
        wait_cycle(p + 1);
        checkOutput("pause_busy", int'(busy), 0);
        checkOutput("pause_addr", int'(note_addr), 3);
        wait_cycle(p + 3);
        startPlay();

        $display("[TB] loop over full ROM, then stop at end");
        loop_en = 1'b1;
        applyStimulus(31, 1'b1);
        loop_en = 1'b0;
        applyStimulus(40, 1'b1);

        $display("[TB] reset, ROM_LAT=3 start latency, reset mid-note");
        wait_cycle(cyc + 2);
        reset = 1'b1;
        wait_cycle(cyc + 1);
        checkResetState("reset2");
        reset = 1'b0;
        cur_addr = 0;
        wait_cycle(cyc + 1);
        c0 = cyc;
        startPlay();
        fork
            begin
                for (int k = 1; k <= LAT3 + 1; k++) begin
                    wait_cycle(c0 + k);
                    checkOutput("lat3_new_note", int'(new_note3), int'(k == LAT3 + 1));
                end
                checkOutput("lat3_addr", int'(note_addr3), 0);
            end
            applyStimulus(7, 1'b1);
        join
        wait_cycle(next_t);
        voice_en  = 2'b11;
        note_done = 2'b00;
        r = next_t + 2;
        wait_cycle(r);
        checkOutput("prereset_addr", int'(note_addr), 7);
        checkOutput("prereset_busy", int'(busy), 1);
        reset = 1'b1;
        play  = 1'b0;
        wait_cycle(r + 1);
        checkResetState("midnote_reset");
        reset = 1'b0;
        wait_cycle(r + 12);
        checkOutput("pending_events", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
